// File: rtl/mem_stage_latch_if.sv
// Data-memory request/response bundle between the MEM pipeline stage
// (master) and the data memory (slave).
interface mem_stage_latch_if;
  logic        dmem_req;
  logic        dmem_wren;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_data;
  logic        dmem_ready;
  logic [31:0] dmem_q;

  modport master (
    output dmem_req,
    output dmem_wren,
    output dmem_addr,
    output dmem_data,
    input  dmem_ready,
    input  dmem_q
  );

  modport slave (
    input  dmem_req,
    input  dmem_wren,
    input  dmem_addr,
    input  dmem_data,
    output dmem_ready,
    output dmem_q
  );
endinterface

// File: rtl/mem_stage_latch.sv
// MEM pipeline stage: X/M latch, data-memory request FSM and M/W latch.
// Define MEM_WM_BYPASS_EN to forward W results into store data.
module mem_stage_latch (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     x_valid,
  input  logic [31:0]              x_instr,
  input  logic [31:0]              x_op,
  input  logic [31:0]              x_B,
  output logic                     x_stall,
  mem_stage_latch_if.master        dmem,
  output logic                     w_valid,
  output logic [31:0]              w_instr,
  output logic [31:0]              w_result
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        xm_valid;
  logic [31:0] xm_instr;
  logic [31:0] xm_op;
  logic [31:0] xm_B;

  logic        x_is_mem;
  logic        xm_is_lw;
  logic        xm_is_sw;

  assign x_is_mem = x_valid && ((x_instr[31:27] == OP_LW) || (x_instr[31:27] == OP_SW));
  assign xm_is_lw = (xm_instr[31:27] == OP_LW);
  assign xm_is_sw = (xm_instr[31:27] == OP_SW);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A completing request may hand straight over to a new memory op loaded on the same edge.
  always_comb begin
    state_next     = state;
    x_stall        = 1'b0;
    dmem.dmem_req  = 1'b0;
    dmem.dmem_wren = 1'b0;
    case (state)
      IDLE: begin
        if (x_is_mem) begin
          state_next = REQ;
        end
      end
      REQ: begin
        dmem.dmem_req  = 1'b1;
        dmem.dmem_wren = xm_is_sw;
        x_stall        = !dmem.dmem_ready;
        if (dmem.dmem_ready) begin
          state_next = x_is_mem ? REQ : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xm_valid <= 1'b0;
      xm_instr <= 32'd0;
      xm_op    <= 32'd0;
      xm_B     <= 32'd0;
    end else if (!x_stall) begin
      xm_valid <= x_valid;
      xm_instr <= x_instr;
      xm_op    <= x_op;
      xm_B     <= x_B;
    end
  end

  // While waiting on memory, W emits bubbles but keeps its last instr/result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_valid  <= 1'b0;
      w_instr  <= 32'd0;
      w_result <= 32'd0;
    end else if (state == IDLE) begin
      w_valid  <= xm_valid;
      w_instr  <= xm_instr;
      w_result <= xm_op;
    end else if (dmem.dmem_ready) begin
      w_valid  <= 1'b1;
      w_instr  <= xm_instr;
      w_result <= xm_is_lw ? dmem.dmem_q : xm_op;
    end else begin
      w_valid  <= 1'b0;
    end
  end

  assign dmem.dmem_addr = xm_op[11:0];

`ifdef MEM_WM_BYPASS_EN
  logic w_writes_reg;
  logic bypass_now;
  logic bypass_hold;

  assign w_writes_reg = (w_instr[31:27] == OP_ADD) ||
                        (w_instr[31:27] == OP_ADDI) ||
                        (w_instr[31:27] == OP_LW);

  assign bypass_now = (state == REQ) && xm_is_sw && w_valid && w_writes_reg &&
                      (w_instr[26:22] == xm_instr[26:22]) && (xm_instr[26:22] != 5'd0);

  // W turns into a bubble after the first wait cycle but w_result holds, so the
  // forwarding decision is remembered to keep store data stable across waits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bypass_hold <= 1'b0;
    end else begin
      bypass_hold <= (state == REQ) && !dmem.dmem_ready && (bypass_now || bypass_hold);
    end
  end

  assign dmem.dmem_data = (bypass_now || bypass_hold) ? w_result : xm_B;
`else
  assign dmem.dmem_data = xm_B;
`endif

endmodule

// File: tb/tb_mem_stage_latch.sv
// Directed self-checking bench for mem_stage_latch: vector table plus
// hand-written stall, reset and bypass sequences.
module tb_mem_stage_latch;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  logic        clock;
  logic        reset;
  logic        x_valid;
  logic [31:0] x_instr;
  logic [31:0] x_op;
  logic [31:0] x_B;
  logic        x_stall;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_result;

  int checks = 0;
  int passes = 0;

  mem_stage_latch_if dmem_bus ();

  mem_stage_latch dut (
    .clock    (clock),
    .reset    (reset),
    .x_valid  (x_valid),
    .x_instr  (x_instr),
    .x_op     (x_op),
    .x_B      (x_B),
    .x_stall  (x_stall),
    .dmem     (dmem_bus),
    .w_valid  (w_valid),
    .w_instr  (w_instr),
    .w_result (w_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        x_valid;
    logic [31:0] x_instr;
    logic [31:0] x_op;
    logic [31:0] x_B;
    logic        ready;
    logic [31:0] q;
    logic        e_req;
    logic        e_stall;
    logic        e_wren;
    logic [11:0] e_addr;
    logic [31:0] e_data;
    logic        e_w_valid;
    logic [31:0] e_w_result;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] mk_instr(input logic [4:0] op, input logic [4:0] rd);
    return {op, rd, 22'd0};
  endfunction

  function automatic vec_t mk_vec(
    input logic v, input logic [31:0] instr, input logic [31:0] op, input logic [31:0] b,
    input logic rdy, input logic [31:0] q,
    input logic req, input logic stall, input logic wren, input logic [11:0] addr,
    input logic [31:0] data, input logic wv, input logic [31:0] wr);
    vec_t r;
    r.x_valid = v;  r.x_instr = instr; r.x_op = op; r.x_B = b;
    r.ready = rdy;  r.q = q;
    r.e_req = req;  r.e_stall = stall; r.e_wren = wren; r.e_addr = addr; r.e_data = data;
    r.e_w_valid = wv; r.e_w_result = wr;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] instr, input logic [31:0] op,
                                input logic [31:0] b, input logic rdy, input logic [31:0] q);
    x_valid = v;
    x_instr = instr;
    x_op    = op;
    x_B     = b;
    dmem_bus.dmem_ready = rdy;
    dmem_bus.dmem_q     = q;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_bypass;

    vecs[0] = mk_vec(1, mk_instr(OP_ADDI, 5'd3), 32'h2A, 32'h0, 0, 32'h0,
                     0, 0, 0, 12'h0, 32'h0, 0, 32'h0);
    vecs[1] = mk_vec(0, mk_instr(OP_LW, 5'd4), 32'h999, 32'h0, 0, 32'h0,
                     0, 0, 0, 12'h0, 32'h0, 1, 32'h2A);
    vecs[2] = mk_vec(1, mk_instr(OP_LW, 5'd6), 32'h104, 32'h0, 0, 32'h0,
                     0, 0, 0, 12'h0, 32'h0, 0, 32'h999);
    vecs[3] = mk_vec(1, mk_instr(OP_ADDI, 5'd8), 32'h33, 32'h0, 1, 32'hDEADBEEF,
                     1, 0, 0, 12'h104, 32'h0, 1, 32'hDEADBEEF);
    vecs[4] = mk_vec(0, 32'h0, 32'h0, 32'h0, 1, 32'h12345678,
                     0, 0, 0, 12'h0, 32'h0, 1, 32'h33);
    vecs[5] = mk_vec(1, mk_instr(OP_SW, 5'd7), 32'h208, 32'hAB, 0, 32'h0,
                     0, 0, 0, 12'h0, 32'h0, 0, 32'h0);
    vecs[6] = mk_vec(1, mk_instr(OP_LW, 5'd10), 32'h10, 32'h0, 1, 32'h5,
                     1, 0, 1, 12'h208, 32'hAB, 1, 32'h208);
    vecs[7] = mk_vec(1, mk_instr(OP_ADDI, 5'd11), 32'h44, 32'h0, 1, 32'hCAFEF00D,
                     1, 0, 0, 12'h010, 32'h0, 1, 32'hCAFEF00D);
    vecs[8] = mk_vec(0, 32'h0, 32'h0, 32'h0, 0, 32'h0,
                     0, 0, 0, 12'h0, 32'h0, 1, 32'h44);

    reset = 1'b0;
    apply_stimulus(0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #2;
    check_output("reset w_valid", {31'd0, w_valid}, 32'h0);
    check_output("reset w_result", w_result, 32'h0);
    check_output("reset w_instr", w_instr, 32'h0);
    check_output("reset dmem_req", {31'd0, dmem_bus.dmem_req}, 32'h0);
    check_output("reset x_stall", {31'd0, x_stall}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].x_valid, vecs[i].x_instr, vecs[i].x_op, vecs[i].x_B,
                     vecs[i].ready, vecs[i].q);
      #1;
      check_output($sformatf("vec%0d dmem_req", i), {31'd0, dmem_bus.dmem_req}, {31'd0, vecs[i].e_req});
      check_output($sformatf("vec%0d x_stall", i), {31'd0, x_stall}, {31'd0, vecs[i].e_stall});
      check_output($sformatf("vec%0d dmem_wren", i), {31'd0, dmem_bus.dmem_wren}, {31'd0, vecs[i].e_wren});
      if (vecs[i].e_req) begin
        check_output($sformatf("vec%0d dmem_addr", i), {20'd0, dmem_bus.dmem_addr}, {20'd0, vecs[i].e_addr});
        check_output($sformatf("vec%0d dmem_data", i), dmem_bus.dmem_data, vecs[i].e_data);
      end
      tick();
      check_output($sformatf("vec%0d w_valid", i), {31'd0, w_valid}, {31'd0, vecs[i].e_w_valid});
      check_output($sformatf("vec%0d w_result", i), w_result, vecs[i].e_w_result);
    end

    // sw held for three wait cycles while an addi waits in X
    apply_stimulus(1, mk_instr(OP_SW, 5'd9), 32'h300, 32'h55, 0, 32'h0);
    tick();
    apply_stimulus(1, mk_instr(OP_ADDI, 5'd12), 32'h66, 32'h0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_output($sformatf("sw wait%0d x_stall", k), {31'd0, x_stall}, 32'h1);
      check_output($sformatf("sw wait%0d dmem_req", k), {31'd0, dmem_bus.dmem_req}, 32'h1);
      check_output($sformatf("sw wait%0d dmem_wren", k), {31'd0, dmem_bus.dmem_wren}, 32'h1);
      check_output($sformatf("sw wait%0d dmem_data", k), dmem_bus.dmem_data, 32'h55);
      check_output($sformatf("sw wait%0d dmem_addr", k), {20'd0, dmem_bus.dmem_addr}, 32'h300);
      tick();
      check_output($sformatf("sw wait%0d w_valid", k), {31'd0, w_valid}, 32'h0);
    end
    dmem_bus.dmem_ready = 1'b1;
    #1;
    check_output("sw done x_stall", {31'd0, x_stall}, 32'h0);
    tick();
    check_output("sw done w_valid", {31'd0, w_valid}, 32'h1);
    check_output("sw done w_result", w_result, 32'h300);
    check_output("sw done w_instr", w_instr, mk_instr(OP_SW, 5'd9));
    apply_stimulus(0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    check_output("after sw dmem_req", {31'd0, dmem_bus.dmem_req}, 32'h0);
    tick();
    check_output("held addi w_valid", {31'd0, w_valid}, 32'h1);
    check_output("held addi w_result", w_result, 32'h66);

    // asynchronous reset while a lw is waiting on memory
    apply_stimulus(1, mk_instr(OP_LW, 5'd13), 32'h123, 32'h0, 0, 32'h0);
    tick();
    apply_stimulus(0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    tick();
    check_output("mid-REQ dmem_req", {31'd0, dmem_bus.dmem_req}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check_output("async reset dmem_req", {31'd0, dmem_bus.dmem_req}, 32'h0);
    check_output("async reset x_stall", {31'd0, x_stall}, 32'h0);
    check_output("async reset w_valid", {31'd0, w_valid}, 32'h0);
    #1;
    reset = 1'b1;
    #1;
    check_output("post reset dmem_req", {31'd0, dmem_bus.dmem_req}, 32'h0);
    check_output("post reset x_stall", {31'd0, x_stall}, 32'h0);
    tick();
    check_output("post reset idle dmem_req", {31'd0, dmem_bus.dmem_req}, 32'h0);
    check_output("post reset w_valid", {31'd0, w_valid}, 32'h0);

    // addi rd=5 followed directly by sw rd=5
`ifdef MEM_WM_BYPASS_EN
    exp_bypass = 32'h77;
`else
    exp_bypass = 32'h11;
`endif
    apply_stimulus(1, mk_instr(OP_ADDI, 5'd5), 32'h77, 32'h0, 0, 32'h0);
    tick();
    apply_stimulus(1, mk_instr(OP_SW, 5'd5), 32'h40, 32'h11, 0, 32'h0);
    tick();
    apply_stimulus(0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    check_output("bypass dmem_req", {31'd0, dmem_bus.dmem_req}, 32'h1);
    check_output("bypass dmem_data", dmem_bus.dmem_data, exp_bypass);
    tick();
    check_output("bypass wait dmem_data", dmem_bus.dmem_data, exp_bypass);
    dmem_bus.dmem_ready = 1'b1;
    tick();
    check_output("bypass sw w_result", w_result, 32'h40);
    check_output("bypass sw w_valid", {31'd0, w_valid}, 32'h1);
    dmem_bus.dmem_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
